// File: rtl/rv_alu_mc_if.sv
// Request/response handshake bundle for the multi-cycle ALU: operands and opcode in, result out.
interface rv_alu_mc_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/rv_alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes and an iterative shifter.
// Define RV_ALU_MC_MUL_EN to add an iterative shift-add MUL on op 11.
module rv_alu_mc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned SHAMT_W    = $clog2(XLEN)
) (
    input  logic       clk,
    input  logic       rst_n,
    rv_alu_mc_if.slave bus,
    output logic       busy
);
    // One extra bit so the counter can also hold XLEN for the multiplier
    localparam int unsigned CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
`ifdef RV_ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd11;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   step;
    logic [XLEN-1:0]    acc_sh;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
`ifdef RV_ALU_MC_MUL_EN
    logic [XLEN-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [XLEN-1:0]    mul_acc;
`endif

    // in_ready depends on out_ready only, never on in_valid
    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign busy          = (state_q != S_IDLE);

    assign accept = bus.in_valid && bus.in_ready;
    assign shamt  = bus.b[SHAMT_W-1:0];

    // One shifter iteration: move acc by at most SHIFT_STEP positions
    always_comb begin
        step = (cnt_q > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : cnt_q;
        case (op_q)
            OP_SLL:  acc_sh = acc_q << step;
            OP_SRL:  acc_sh = acc_q >> step;
            default: acc_sh = $signed(acc_q) >>> step;
        endcase
    end

`ifdef RV_ALU_MC_MUL_EN
    assign mul_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
`ifdef RV_ALU_MC_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
`ifdef RV_ALU_MC_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d    = mul_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = mul_acc;
                        state_d  = S_DONE;
                    end
                end else
`endif
                begin
                    acc_d = acc_sh;
                    cnt_d = cnt_q - step;
                    if (cnt_q == step) begin
                        result_d = acc_sh;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new accept (from IDLE or back-to-back from DONE) overrides the above
        if (accept) begin
            op_d      = bus.op;
            illegal_d = 1'b0;
            state_d   = S_DONE;
            case (bus.op)
                OP_ADD:   result_d = bus.a + bus.b;
                OP_SUB:   result_d = bus.a - bus.b;
                OP_AND:   result_d = bus.a & bus.b;
                OP_OR:    result_d = bus.a | bus.b;
                OP_XOR:   result_d = bus.a ^ bus.b;
                OP_SLT:   result_d = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                OP_SLTU:  result_d = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
                OP_PASSB: result_d = bus.b;
                OP_SLL, OP_SRL, OP_SRA: begin
                    acc_d = bus.a;
                    cnt_d = CNT_W'(shamt);
                    if (shamt == '0) begin
                        result_d = bus.a;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
`ifdef RV_ALU_MC_MUL_EN
                OP_MUL: begin
                    acc_d    = '0;
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    cnt_d    = CNT_W'(XLEN);
                    state_d  = S_BUSY;
                end
`endif
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
`ifdef RV_ALU_MC_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
`ifdef RV_ALU_MC_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`endif
        end
    end
endmodule

// File: tb/tb_rv_alu_mc.sv
// Directed bench for rv_alu_mc (XLEN=32, SHIFT_STEP=4); MUL check follows RV_ALU_MC_MUL_EN.
module tb_rv_alu_mc;
    logic clk;
    logic rst_n;
    logic busy;
    int   ntests = 0;
    int   nfail  = 0;

    rv_alu_mc_if #(.XLEN(32)) bus ();

    rv_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; lat counts cycles from the accept edge
    task automatic wait_valid(input int maxc, output int lat, output logic rdy_busy);
        lat      = 1;
        rdy_busy = 1'b0;
        while (!bus.out_valid && lat < maxc) begin
            if (bus.in_ready) rdy_busy = 1'b1;
            tick();
            lat++;
        end
    endtask

    // Issue one op with out_ready high, check result/illegal/latency, then drain
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_ill, input int exp_lat);
        int   lat;
        logic rdy_busy;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0000_0003;
        wait_valid(exp_lat + 5, lat, rdy_busy);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'(exp_ill));
        chk({tag, "_rdy_in_busy"}, 64'(rdy_busy), 64'(0));
        tick();
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        logic stale;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_illegal", 64'(bus.illegal), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        run("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1);
        run("sub",      4'd1,  32'h5,         32'h7,        32'hFFFF_FFFE, 1'b0, 1);
        run("and",      4'd2,  32'hF0F0,      32'hFF00,     32'hF000,      1'b0, 1);
        run("slt",      4'd5,  32'hFFFF_FFFE, 32'h1,        32'h1,         1'b0, 1);
        run("sltu",     4'd6,  32'hFFFF_FFFE, 32'h1,        32'h0,         1'b0, 1);
        run("passb",    4'd10, 32'h1111_1111, 32'h1234_5678,32'h1234_5678, 1'b0, 1);
        run("sra31",    4'd9,  32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 9);
        run("sll0",     4'd7,  32'h1,         32'h0,        32'h1,         1'b0, 1);
        run("srl5",     4'd8,  32'hF000_0000, 32'd5,        32'h0780_0000, 1'b0, 3);
        run("sll8",     4'd7,  32'h1,         32'd8,        32'h100,       1'b0, 3);
        run("sra4",     4'd9,  32'hF000_0000, 32'd4,        32'hFF00_0000, 1'b0, 2);
        run("srl_trunc",4'd8,  32'h80,        32'h23,       32'h10,        1'b0, 2);
        run("ill13",    4'd13, 32'h5,         32'h6,        32'h0,         1'b1, 1);
        run("ill15",    4'd15, 32'h5,         32'h6,        32'h0,         1'b1, 1);
`ifdef RV_ALU_MC_MUL_EN
        run("mul",      4'd11, 32'd7,         32'd6,        32'd42,        1'b0, 33);
`else
        run("op11_ill", 4'd11, 32'd7,         32'd6,        32'd0,         1'b1, 1);
`endif
        run("add_after_ill", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // Back-to-back ADD then XOR with out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.a         = 32'd1;
        bus.b         = 32'd2;
        tick();
        bus.op = 4'd4;
        bus.a  = 32'hF0;
        bus.b  = 32'hFF;
        chk("b2b_valid1", 64'(bus.out_valid), 64'(1));
        chk("b2b_result1", 64'(bus.result), 64'(3));
        chk("b2b_in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_valid2", 64'(bus.out_valid), 64'(1));
        chk("b2b_result2", 64'(bus.result), 64'(32'h0F));
        tick();
        chk("b2b_drop", 64'(bus.out_valid), 64'(0));

        // Result held while out_ready is low; a pending request is not accepted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd3;
        bus.a         = 32'h0F00;
        bus.b         = 32'h00F0;
        tick();
        bus.op = 4'd2;
        bus.a  = 32'h0;
        bus.b  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_result", 64'(bus.result), 64'(32'h0FF0));
            chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("hold_result_end", 64'(bus.result), 64'(32'h0FF0));
        tick();
        chk("hold_drop", 64'(bus.out_valid), 64'(0));

        // Reset in the middle of an SRL abandons it
        bus.in_valid = 1'b1;
        bus.op       = 4'd8;
        bus.a        = 32'h8000_0000;
        bus.b        = 32'd20;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mid_busy", 64'(busy), 64'(1));
        chk("mid_valid", 64'(bus.out_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_result", 64'(bus.result), 64'(0));
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) stale = 1'b1;
            tick();
        end
        chk("mid_no_stale", 64'(stale), 64'(0));
        run("add_post_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
